// File: rtl/int_prio_ctrl.sv
// Registered interrupt priority controller: edge-captured pending bits, per-source mask,
// fixed or round-robin selection; the chosen source is held until irq_ack.
module int_prio_ctrl #(
  parameter  int N  = 8,
  parameter  int RR = 0,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  int_req,
  input  logic [N-1:0]  int_mask,
  input  logic          irq_ack,
  output logic          irq,
  output logic [N-1:0]  rout_addrs,
  output logic [IW-1:0] rout_id,
  output logic [N-1:0]  pend
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  req_q;
  logic [N-1:0]  rise;
  logic [N-1:0]  clr;
  logic [N-1:0]  eligible;
  logic [N-1:0]  addrs_nxt;
  logic [IW-1:0] id_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] win_id;
  logic [IW-1:0] idx;
  logic          win_found;

  assign rise     = int_req & ~req_q;
  assign clr      = (state == ISSUE && irq_ack) ? rout_addrs : '0;
  assign eligible = pend & ~int_mask;
  assign irq      = (state == ISSUE);

  // Search order starts at index 0 (fixed) or just after the last acked ID (round-robin).
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      if (RR != 0) idx = IW'((int'(ptr) + 1 + k) % N);
      else         idx = IW'(k);
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    addrs_nxt = rout_addrs;
    id_nxt    = rout_id;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (|eligible) begin
          state_nxt = ISSUE;
          addrs_nxt = {{(N-1){1'b0}}, 1'b1} << win_id;
          id_nxt    = win_id;
        end
      end
      ISSUE: begin
        if (irq_ack) begin
          state_nxt = IDLE;
          addrs_nxt = '0;
          id_nxt    = '0;
          if (RR != 0) ptr_nxt = rout_id;
        end
      end
    endcase
  end

  // A rise on the same edge as its clear keeps the bit pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rout_addrs <= '0;
      rout_id    <= '0;
      pend       <= '0;
      req_q      <= '0;
      ptr        <= IW'(N - 1);
    end else begin
      state      <= state_nxt;
      rout_addrs <= addrs_nxt;
      rout_id    <= id_nxt;
      pend       <= (pend & ~clr) | rise;
      req_q      <= int_req;
      ptr        <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_int_prio_ctrl.sv
// Bench for int_prio_ctrl: fixed-priority and round-robin instances share request/mask
// stimulus; directed scenarios plus random traffic are checked against a behavioural model.
module tb_int_prio_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] int_req;
  logic [7:0] int_mask;
  logic       ack0, ack1;
  logic       irq0, irq1;
  logic [7:0] addrs0, addrs1;
  logic [2:0] id0, id1;
  logic [7:0] pend0, pend1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: per instance pending set, presented source, last acked ID.
  logic [7:0] m_pend [2];
  logic       m_busy [2];
  int         m_id   [2];
  int         m_ptr  [2];
  logic [7:0] m_reqq;

  int g0[$];
  int g1[$];

  always #5 clk = ~clk;

  int_prio_ctrl #(.N(8), .RR(0)) dut_fix (
    .clk(clk), .rst(rst), .int_req(int_req), .int_mask(int_mask), .irq_ack(ack0),
    .irq(irq0), .rout_addrs(addrs0), .rout_id(id0), .pend(pend0)
  );

  int_prio_ctrl #(.N(8), .RR(1)) dut_rr (
    .clk(clk), .rst(rst), .int_req(int_req), .int_mask(int_mask), .irq_ack(ack1),
    .irq(irq1), .rout_addrs(addrs1), .rout_id(id1), .pend(pend1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [7:0] rise;
    logic [7:0] elig;
    logic       ack;
    logic       found;
    int         idx;
    rise = int_req & ~m_reqq;
    for (int r = 0; r < 2; r++) begin
      ack = (r == 0) ? ack0 : ack1;
      if (rst) begin
        m_pend[r] = 8'h00;
        m_busy[r] = 1'b0;
        m_id[r]   = 0;
        m_ptr[r]  = 7;
      end else if (m_busy[r]) begin
        if (ack) begin
          m_pend[r] = (m_pend[r] & ~(8'h01 << m_id[r])) | rise;
          m_busy[r] = 1'b0;
          if (r == 1) m_ptr[r] = m_id[r];
        end else begin
          m_pend[r] = m_pend[r] | rise;
        end
      end else begin
        elig  = m_pend[r] & ~int_mask;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
          idx = (r == 1) ? (m_ptr[r] + 1 + k) % 8 : k;
          if (!found && elig[idx]) begin
            found     = 1'b1;
            m_busy[r] = 1'b1;
            m_id[r]   = idx;
          end
        end
        m_pend[r] = m_pend[r] | rise;
      end
    end
    m_reqq = rst ? 8'h00 : int_req;
  endtask

  task automatic cmp_inst(input int r, input logic irq, input logic [2:0] id,
                          input logic [7:0] addrs, input logic [7:0] pend);
    int e_id;
    e_id = m_busy[r] ? m_id[r] : 0;
    chk($sformatf("r%0d irq", r), 32'(irq), 32'(m_busy[r]));
    chk($sformatf("r%0d rout_id", r), 32'(id), 32'(e_id));
    chk($sformatf("r%0d rout_addrs", r), 32'(addrs), m_busy[r] ? (32'h1 << e_id) : 32'h0);
    chk($sformatf("r%0d pend", r), 32'(pend), 32'(m_pend[r]));
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cmp_inst(0, irq0, id0, addrs0, pend0);
    cmp_inst(1, irq1, id1, addrs1, pend1);
  endtask

  task automatic do_reset();
    rst = 1'b1; int_req = 8'h00; int_mask = 8'h00; ack0 = 1'b0; ack1 = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Acknowledge whatever each instance presents; optionally re-raise sources 0 and 4 on acks.
  task automatic run_auto(input int cycles, input bit repulse);
    logic p0, p1;
    p0 = irq0; p1 = irq1;
    g0.delete(); g1.delete();
    for (int c = 0; c < cycles; c++) begin
      ack0    = irq0;
      ack1    = irq1;
      int_req = (repulse && (irq0 || irq1)) ? 8'h11 : 8'h00;
      tick();
      if (irq0 && !p0) g0.push_back(int'(id0));
      if (irq1 && !p1) g1.push_back(int'(id1));
      p0 = irq0; p1 = irq1;
    end
    ack0 = 1'b0; ack1 = 1'b0; int_req = 8'h00;
  endtask

  task automatic pulse(input logic [7:0] v);
    int_req = v;
    tick();
    int_req = 8'h00;
  endtask

  initial begin
    int exp_fix [3];
    int exp_rr  [4];
    m_reqq = 8'h00;
    rst = 1'b1; int_req = 8'hFF; int_mask = 8'h00; ack0 = 1'b0; ack1 = 1'b0;
    @(negedge clk);

    // Reset with all requests held high, then release.
    tick(); tick();
    chk("rst irq", 32'(irq0), 32'h0);
    chk("rst pend", 32'(pend0), 32'h0);
    chk("rst addrs", 32'(addrs0), 32'h0);
    rst = 1'b0;
    tick();
    chk("rel pend", 32'(pend0), 32'hFF);
    chk("rel irq", 32'(irq0), 32'h0);
    tick();
    chk("rel irq1", 32'(irq0), 32'h1);
    chk("rel id", 32'(id0), 32'h0);
    chk("rel addrs", 32'(addrs0), 32'h01);
    chk("rel rr id", 32'(id1), 32'h0);
    run_auto(20, 1'b0);
    chk("drain pend", 32'(pend0), 32'h0);
    do_reset();

    // Fixed priority ordering over pend=0x2C.
    pulse(8'h2C);
    run_auto(8, 1'b0);
    exp_fix = '{2, 3, 5};
    chk("fix count", 32'(g0.size()), 32'd3);
    for (int i = 0; i < g0.size() && i < 3; i++) chk("fix grant", 32'(g0[i]), 32'(exp_fix[i]));
    chk("fix pend end", 32'(pend0), 32'h0);
    do_reset();

    // Masked source latches but waits for unmask.
    int_mask = 8'h02;
    pulse(8'h02);
    chk("mask pend", 32'(pend0), 32'h02);
    chk("mask irq", 32'(irq0), 32'h0);
    tick();
    chk("mask irq hold", 32'(irq0), 32'h0);
    int_mask = 8'h00;
    tick();
    chk("unmask irq", 32'(irq0), 32'h1);
    chk("unmask addrs", 32'(addrs0), 32'h02);
    do_reset();

    // Re-raise on the acknowledge edge keeps the bit pending.
    pulse(8'h10);
    tick();
    chk("sc id", 32'(id0), 32'd4);
    ack0 = 1'b1; ack1 = 1'b1; int_req = 8'h10;
    tick();
    chk("sc irq low", 32'(irq0), 32'h0);
    chk("sc pend", 32'(pend0), 32'h10);
    ack0 = 1'b0; ack1 = 1'b0; int_req = 8'h00;
    tick();
    chk("sc irq again", 32'(irq0), 32'h1);
    chk("sc id again", 32'(id0), 32'd4);
    do_reset();

    // Round-robin alternation versus fixed priority with pend held at 0x11.
    pulse(8'h11);
    run_auto(8, 1'b1);
    exp_rr = '{0, 4, 0, 4};
    chk("rr count", 32'(g1.size()), 32'd4);
    for (int i = 0; i < g1.size() && i < 4; i++) chk("rr grant", 32'(g1[i]), 32'(exp_rr[i]));
    chk("fix rr count", 32'(g0.size()), 32'd4);
    for (int i = 0; i < g0.size() && i < 4; i++) chk("fix rr grant", 32'(g0[i]), 32'd0);
    do_reset();

    // Reset while presenting source 6, then a stray acknowledge.
    pulse(8'h40);
    tick();
    chk("ri id", 32'(id0), 32'd6);
    rst = 1'b1;
    tick();
    chk("ri irq", 32'(irq0), 32'h0);
    chk("ri pend", 32'(pend0), 32'h0);
    rst = 1'b0; ack0 = 1'b1; ack1 = 1'b1;
    tick();
    chk("ri ack irq", 32'(irq0), 32'h0);
    chk("ri ack pend", 32'(pend0), 32'h0);
    ack0 = 1'b0; ack1 = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      rst      = ($urandom_range(0, 99) == 0);
      int_req  = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      int_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
      ack0     = 1'($urandom_range(0, 1));
      ack1     = 1'($urandom_range(0, 1));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
